// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg: shared state type and default parameters for the round-robin arbiter
package rr_arb_pkg;
  typedef enum logic {IDLE, GRANT} arb_state_e;
  localparam int DEFAULT_N = 4;
  localparam int DEFAULT_MAX_HOLD = 8;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational rotating-priority picker, first set req bit at or after ptr wins
module rr_pick #(
  parameter int N = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] winner,
  output logic          valid
);
  assign valid = |req;
  // scan farthest offset first so the nearest requester overwrites it
  always_comb begin
    winner = '0;
    for (int i = N - 1; i >= 0; i--)
      if (req[IW'((int'(ptr) + i) % N)]) winner = IW'((int'(ptr) + i) % N);
  end
endmodule

// File: rtl/rr_req_arbiter.sv
// rr_req_arbiter: round-robin request/grant arbiter with bounded hold time.
// Define RR_ARB_ASSERT_EN to elaborate the built-in grant-contract assertions.
module rr_req_arbiter
  import rr_arb_pkg::*;
#(
  parameter int N = DEFAULT_N,
  parameter int MAX_HOLD = DEFAULT_MAX_HOLD,
  localparam int IW = $clog2(N),
  localparam int HW = $clog2(MAX_HOLD + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_id,
  output logic          busy,
  output logic          timeout
);
  arb_state_e state;
  logic [IW-1:0] ptr;
  logic [HW-1:0] hold_cnt;
  logic [IW-1:0] winner;
  logic valid;
  rr_pick #(.N(N), .IW(IW)) u_pick (.req(req), .ptr(ptr), .winner(winner), .valid(valid));
  assign busy = (state == GRANT);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= '0;
      gnt_id   <= '0;
      timeout  <= 1'b0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      timeout <= 1'b0;
      if (state == IDLE) begin
        if (valid) begin
          state    <= GRANT;
          gnt      <= N'(1) << winner;
          gnt_id   <= winner;
          ptr      <= (winner == IW'(N - 1)) ? '0 : winner + 1'b1;
          hold_cnt <= HW'(1);
        end
      end else if (!req[gnt_id] || hold_cnt == HW'(MAX_HOLD)) begin
        state   <= IDLE;
        gnt     <= '0;
        gnt_id  <= '0;
        timeout <= req[gnt_id];
      end else begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end
`ifdef RR_ARB_ASSERT_EN
  a_idle_grant: assert property (@(posedge clk) disable iff (!rst_n) (state == IDLE && |req) |=> |gnt)
    $info("%0t a_idle_grant ok req=%b gnt=%b", $time, req, gnt);
    else $error("%0t a_idle_grant violated req=%b gnt=%b", $time, req, gnt);
  a_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt))
    $info("%0t a_onehot ok req=%b gnt=%b", $time, req, gnt);
    else $error("%0t a_onehot violated req=%b gnt=%b", $time, req, gnt);
  a_keep: assert property (@(posedge clk) disable iff (!rst_n) (|gnt && req[gnt_id]) |=> (|gnt || timeout))
    $info("%0t a_keep ok req=%b gnt=%b", $time, req, gnt);
    else $error("%0t a_keep violated req=%b gnt=%b", $time, req, gnt);
  for (genvar i = 0; i < N; i++) begin : g_req_chk
    a_gnt_req: assert property (@(posedge clk) disable iff (!rst_n) gnt[i] |-> $past(req[i]))
      $info("%0t a_gnt_req[%0d] ok req=%b gnt=%b", $time, i, req, gnt);
      else $error("%0t a_gnt_req[%0d] violated req=%b gnt=%b", $time, i, req, gnt);
  end
`endif
endmodule

// File: tb/tb_rr_req_arbiter.sv
// tb_rr_req_arbiter: directed checks of grant order, release, hold limit and async reset
module tb_rr_req_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] req, req1, gnt, gnt1;
  logic [1:0] gnt_id, gnt_id1;
  logic busy, busy1, timeout, timeout1;
  int errors = 0;
  int checks = 0;
  int order [5] = '{0, 1, 2, 3, 0};
  rr_req_arbiter #(.N(4), .MAX_HOLD(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt),
    .gnt_id(gnt_id), .busy(busy), .timeout(timeout)
  );
  rr_req_arbiter #(.N(4), .MAX_HOLD(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req1), .gnt(gnt1),
    .gnt_id(gnt_id1), .busy(busy1), .timeout(timeout1)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
  endtask
  task automatic outs(input string tag, input logic [3:0] eg, input logic [1:0] eid, input logic eb, input logic et);
    check({tag, ".gnt"}, 32'(gnt), 32'(eg));
    check({tag, ".gnt_id"}, 32'(gnt_id), 32'(eid));
    check({tag, ".busy"}, 32'(busy), 32'(eb));
    check({tag, ".timeout"}, 32'(timeout), 32'(et));
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask
  initial begin
    rst_n = 1'b0;
    req = '0;
    req1 = '0;
    step();
    step();
    outs("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();
    outs("idle_noreq", 4'b0000, 2'd0, 1'b0, 1'b0);
    // single request from requester 2
    req = 4'b0100;
    step();
    outs("single", 4'b0100, 2'd2, 1'b1, 1'b0);
    check("single.ptr", 32'(dut.ptr), 32'd3);
    req = 4'b0000;
    step();
    outs("single_rel", 4'b0000, 2'd0, 1'b0, 1'b0);
    // all requesting from ptr=0, each owner drops for one cycle
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("rr%0d.gnt", k), 32'(gnt), 32'(4'b0001 << order[k]));
      check($sformatf("rr%0d.id", k), 32'(gnt_id), 32'(order[k]));
      req = 4'b1111 & ~(4'b0001 << order[k]);
      step();
      check($sformatf("rr%0d.bubble", k), 32'(gnt), 32'd0);
      req = 4'b1111;
    end
    req = 4'b0000;
    step();
    // owner 1 releases after three granted cycles (ptr is 1 here)
    req = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      step();
      outs($sformatf("hold1_%0d", k), 4'b0010, 2'd1, 1'b1, 1'b0);
    end
    req = 4'b0000;
    step();
    outs("release", 4'b0000, 2'd0, 1'b0, 1'b0);
    // hold limit: owner 0 keeps requesting with requester 2 waiting
    do_reset();
    req = 4'b0101;
    for (int k = 0; k < 8; k++) begin
      step();
      outs($sformatf("maxhold%0d", k), 4'b0001, 2'd0, 1'b1, 1'b0);
    end
    step();
    outs("forced", 4'b0000, 2'd0, 1'b0, 1'b1);
    step();
    outs("after_to", 4'b0100, 2'd2, 1'b1, 1'b0);
    req = 4'b0001;
    step();
    outs("after_to_rel", 4'b0000, 2'd0, 1'b0, 1'b0);
    step();
    outs("regrant0", 4'b0001, 2'd0, 1'b1, 1'b0);
    req = 4'b0000;
    step();
    // async reset while requester 3 owns the grant (ptr is 1 here)
    req = 4'b1000;
    step();
    outs("pre_rst", 4'b1000, 2'd3, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    req = 4'b1001;
    #1;
    outs("async_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    outs("post_rst", 4'b0001, 2'd0, 1'b1, 1'b0);
    req = 4'b0000;
    // MAX_HOLD=1: one-cycle grants and a timeout whenever the owner persists
    req1 = 4'b0001;
    step();
    check("mh1.gnt", 32'(gnt1), 32'd1);
    check("mh1.to", 32'(timeout1), 32'd0);
    step();
    check("mh1.forced.gnt", 32'(gnt1), 32'd0);
    check("mh1.forced.to", 32'(timeout1), 32'd1);
    req1 = 4'b0011;
    step();
    check("mh1.regrant", 32'(gnt1), 32'd2);
    check("mh1.regrant.to", 32'(timeout1), 32'd0);
    req1 = 4'b0000;
    step();
    check("mh1.release.to", 32'(timeout1), 32'd0);
    check("mh1.release.busy", 32'(busy1), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
